// File: rtl/dma_priority_arbiter_if.sv
// Handshake and control bundle between a DMA requester side and dma_priority_arbiter.
// master: environment side (drives requests/controls); slave: the arbiter.
interface dma_priority_arbiter_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = $clog2(NUM_CH)
);
    logic [NUM_CH-1:0] DREQ;
    logic              HLDA;
    logic              EOP_N;
    logic              XFER_DONE;
    logic              PRIORITY_TYPE;
    logic [NUM_CH-1:0] AUTOINIT;
    logic              MASK_WE;
    logic [CH_W-1:0]   MASK_SEL;
    logic              MASK_BIT;
    logic              STATUS_RD;
    logic              HRQ;
    logic [NUM_CH-1:0] DACK;
    logic [CH_W-1:0]   ACTIVE_CH;
    logic [NUM_CH-1:0] TC_STATUS;
    logic [NUM_CH-1:0] MASK;
    logic              GRANT_ABORT;

    modport master (
        output DREQ, HLDA, EOP_N, XFER_DONE, PRIORITY_TYPE, AUTOINIT,
               MASK_WE, MASK_SEL, MASK_BIT, STATUS_RD,
        input  HRQ, DACK, ACTIVE_CH, TC_STATUS, MASK, GRANT_ABORT
    );

    modport slave (
        input  DREQ, HLDA, EOP_N, XFER_DONE, PRIORITY_TYPE, AUTOINIT,
               MASK_WE, MASK_SEL, MASK_BIT, STATUS_RD,
        output HRQ, DACK, ACTIVE_CH, TC_STATUS, MASK, GRANT_ABORT
    );
endinterface

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter: hold-request handshake, fixed/rotating priority grant,
// terminal-count status and channel mask registers. All outputs registered.
// Optional macro DMA_ROTATING_PRIORITY_EN enables rotating priority (PRIORITY_TYPE=1);
// without it priority is always fixed and no pointer register exists.
module dma_priority_arbiter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
    input logic                   CLK,
    input logic                   RESET_N,
    dma_priority_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        GRANT = 2'd2
    } arbStateT;

    arbStateT          stateReg;
    arbStateT          stateNext;

    logic              hrqReg;
    logic              hrqNext;
    logic [NUM_CH-1:0] dackReg;
    logic [NUM_CH-1:0] dackNext;
    logic [CH_W-1:0]   activeChReg;
    logic [CH_W-1:0]   activeChNext;
    logic              abortReg;
    logic              abortNext;
    logic [NUM_CH-1:0] tcReg;
    logic [NUM_CH-1:0] tcNext;
    logic [NUM_CH-1:0] maskReg;
    logic [NUM_CH-1:0] maskNext;

    logic [NUM_CH-1:0] effReq;
    logic [CH_W-1:0]   arbPtr;
    logic [CH_W-1:0]   pickCh;
    logic              pickFound;
    logic              grantEnd;
    logic              eopHit;

    // Channel at priority rank 'offs' when 'ptr' holds the highest-priority channel.
    function automatic logic [CH_W-1:0] rotIdx(input logic [CH_W-1:0] ptr, input int unsigned offs);
        int unsigned sum;
        sum = 32'(ptr) + offs;
        if (sum >= NUM_CH) begin
            sum = sum - NUM_CH;
        end
        return CH_W'(sum);
    endfunction

    assign effReq = bus.DREQ & ~maskReg;

`ifdef DMA_ROTATING_PRIORITY_EN
    logic [CH_W-1:0] ptrReg;

    assign arbPtr = bus.PRIORITY_TYPE ? ptrReg : '0;

    // After a completed grant the channel following the winner becomes highest priority.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            ptrReg <= '0;
        end else if (grantEnd && bus.PRIORITY_TYPE) begin
            ptrReg <= (32'(activeChReg) == NUM_CH - 1) ? '0 : activeChReg + CH_W'(1);
        end
    end
`else
    logic unusedPriorityType;

    assign unusedPriorityType = bus.PRIORITY_TYPE;
    assign arbPtr             = '0;
`endif

    // Highest-priority requesting channel, scanning from the pointer upward with wrap.
    always_comb begin
        pickCh    = '0;
        pickFound = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!pickFound && effReq[rotIdx(arbPtr, i)]) begin
                pickCh    = rotIdx(arbPtr, i);
                pickFound = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        stateNext    = stateReg;
        activeChNext = activeChReg;
        abortNext    = 1'b0;
        grantEnd     = 1'b0;
        eopHit       = 1'b0;

        unique case (stateReg)
            IDLE: begin
                if (|effReq) begin
                    stateNext = REQ;
                end
            end
            REQ: begin
                if (!(|effReq)) begin
                    stateNext = IDLE;
                end else if (bus.HLDA) begin
                    stateNext    = GRANT;
                    activeChNext = pickCh;
                end
            end
            GRANT: begin
                // Losing HLDA wins over a simultaneous end of transfer.
                if (!bus.HLDA) begin
                    stateNext = IDLE;
                    abortNext = 1'b1;
                end else if (!bus.EOP_N || bus.XFER_DONE) begin
                    stateNext = IDLE;
                    grantEnd  = 1'b1;
                    eopHit    = !bus.EOP_N;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        hrqNext  = (stateNext != IDLE);
        dackNext = '0;
        tcNext   = bus.STATUS_RD ? '0 : tcReg;
        maskNext = maskReg;

        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (stateNext == GRANT && activeChNext == CH_W'(c)) begin
                dackNext[c] = 1'b1;
            end
            if (bus.MASK_WE && bus.MASK_SEL == CH_W'(c)) begin
                maskNext[c] = bus.MASK_BIT;
            end
            // Terminal count sets override a same-cycle status clear or mask write.
            if (eopHit && activeChReg == CH_W'(c)) begin
                tcNext[c] = 1'b1;
                if (!bus.AUTOINIT[c]) begin
                    maskNext[c] = 1'b1;
                end
            end
        end
    end

    // Registered outputs and status/mask registers.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            hrqReg      <= 1'b0;
            dackReg     <= '0;
            activeChReg <= '0;
            abortReg    <= 1'b0;
            tcReg       <= '0;
            maskReg     <= '1;
        end else begin
            hrqReg      <= hrqNext;
            dackReg     <= dackNext;
            activeChReg <= activeChNext;
            abortReg    <= abortNext;
            tcReg       <= tcNext;
            maskReg     <= maskNext;
        end
    end

    assign bus.HRQ         = hrqReg;
    assign bus.DACK        = dackReg;
    assign bus.ACTIVE_CH   = activeChReg;
    assign bus.GRANT_ABORT = abortReg;
    assign bus.TC_STATUS   = tcReg;
    assign bus.MASK        = maskReg;

endmodule

// File: doc/dma_priority_arbiter.md
DMA_PRIORITY_ARBITER -- requirements
Module: dma_priority_arbiter

Interface
REQ-001 Parameters (name, default, meaning); NUM_CH is legal in 2..8:
- NUM_CH, 4, number of DMA channels.
- CH_W, $clog2(NUM_CH), width of the channel index.
REQ-002 Ports (name, direction, width, meaning):
- CLK, in, 1, single clock; all state updates on the rising edge.
- RESET_N, in, 1, reset; synchronous, active-low.
- DREQ, in, NUM_CH, per-channel DMA request, active-high.
- HLDA, in, 1, hold acknowledge from the CPU.
- EOP_N, in, 1, end of process, active-low.
- XFER_DONE, in, 1, single-cycle pulse from transfer timing: the current transfer has completed.
- PRIORITY_TYPE, in, 1, priority mode: 0 = fixed, 1 = rotating.
- AUTOINIT, in, NUM_CH, per-channel autoinitialize enable.
- MASK_WE, in, 1, single-mask write strobe.
- MASK_SEL, in, CH_W, channel selected for a mask write.
- MASK_BIT, in, 1, value written to the selected mask bit.
- STATUS_RD, in, 1, status read pulse; clears TC_STATUS.
- HRQ, out, 1, hold request to the CPU.
- DACK, out, NUM_CH, one-hot DMA acknowledge.
- ACTIVE_CH, out, CH_W, index of the granted channel.
- TC_STATUS, out, NUM_CH, sticky terminal-count flags.
- MASK, out, NUM_CH, current mask register.
- GRANT_ABORT, out, 1, single-cycle pulse: grant lost because HLDA dropped.

Function
REQ-003 Effective request: effReq = DREQ & ~MASK, evaluated every cycle.
REQ-004 FSM states: IDLE, REQ, GRANT. All outputs are registered.
REQ-005 IDLE: HRQ=0, DACK=0. If |effReq, go to REQ; HRQ=1 on the next cycle.
REQ-006 REQ: HRQ=1, DACK=0.
- If HLDA=1 and |effReq: go to GRANT and latch the winner, which is the highest-priority channel in effReq on that cycle.
- If effReq=0, whatever HLDA is: go to IDLE; HRQ=0 on the next cycle.
REQ-007 GRANT: HRQ=1, DACK=one-hot(winner), ACTIVE_CH=winner. DACK appears exactly one cycle after the HLDA-sampled edge. Winner and DACK are stable for the whole GRANT.
REQ-008 GRANT exits:
- EOP_N=0 or XFER_DONE=1 ends the grant: go to IDLE; HRQ=0 and DACK=0 on the next cycle.
- HLDA=0 aborts the grant: go to IDLE and pulse GRANT_ABORT for 1 cycle.
- HLDA=0 takes precedence over a simultaneous EOP_N/XFER_DONE: no TC or mask update occurs.
REQ-009 Fixed priority: channel 0 is highest, then ascending index; channel NUM_CH-1 is lowest.
REQ-010 Rotating priority: after a grant ends (EOP or XFER_DONE, not abort), the last winner becomes lowest priority and winner+1 (mod NUM_CH) becomes highest.
REQ-011 The priority pointer is modulo NUM_CH and wraps from NUM_CH-1 to 0.
REQ-012 The priority pointer is unchanged on abort, or when PRIORITY_TYPE=0. A PRIORITY_TYPE change takes effect at the next arbitration.
REQ-013 EOP_N=0 in GRANT:
- Sets TC_STATUS[winner].
- Sets MASK[winner] unless AUTOINIT[winner]=1.
- XFER_DONE alone does neither.
REQ-014 STATUS_RD=1 clears TC_STATUS on the next cycle. A simultaneous set for the same bit wins over the clear.
REQ-015 MASK_WE=1 writes MASK[MASK_SEL]=MASK_BIT on the next cycle. A simultaneous EOP-set of the same bit wins.
REQ-016 Masking the winner during GRANT does not end the grant; the mask takes effect at the next arbitration.
REQ-017 DACK is never multi-hot. DACK≠0 implies HRQ=1 and state=GRANT.

Reset
REQ-018 On RESET_N=0 at a rising edge, the block enters IDLE with:
- HRQ=0, DACK=0, ACTIVE_CH=0, GRANT_ABORT=0.
- TC_STATUS=0, MASK=all ones.
- Priority pointer=0 (channel 0 highest).
REQ-019 Reset mid-GRANT drops DACK and HRQ on the same edge. No TC or mask side effects occur.

Configuration
REQ-020 Macro DMA_ROTATING_PRIORITY_EN.
- Defined: PRIORITY_TYPE selects fixed or rotating per REQ-009..REQ-012.
- Undefined: PRIORITY_TYPE is ignored, priority is always fixed, and the pointer logic is not synthesized.

Verification
REQ-021 Bench scenarios, NUM_CH=4, macro defined:
- Reset, MASK cleared, DREQ=4'b1010, HLDA=1 two cycles later -> HRQ=1 one cycle after DREQ; DACK=4'b0010 and ACTIVE_CH=1 one cycle after HLDA.
- Rotating mode, DREQ=4'b1111 held, four grants each ended by XFER_DONE -> DACK sequence 0001, 0010, 0100, 1000, then wraps to 0001.
- GRANT on ch2 with AUTOINIT=0, EOP_N=0 -> TC_STATUS=4'b0100, MASK[2]=1, HRQ=0 the next cycle. Repeat with AUTOINIT[2]=1 -> MASK[2] stays 0.
- GRANT on ch0, HLDA drops -> GRANT_ABORT pulses 1 cycle, DACK=0, TC_STATUS unchanged, pointer unchanged.
- STATUS_RD and EOP_N=0 on ch3 in the same cycle -> TC_STATUS[3]=1, other TC bits cleared.
- RESET_N=0 while in GRANT -> DACK=0, HRQ=0, MASK=4'b1111 on the next edge; DREQ=4'b1111 then yields no HRQ until a mask bit is cleared.
